// File: rtl/idma_legacy_burst_scheduler.sv
// Shares one legacy 1D iDMA backend between NumReq requesters. Arbitration is round-robin,
// and an in-order tracking FIFO routes completions. Define IDMA_SCHED_PRIO_EN to add prio_i.
package idma_legacy_burst_scheduler_pkg;
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } burst_req_t;
endpackage

module idma_legacy_burst_scheduler #(
  parameter int unsigned  NumReq         = 4,
  parameter int unsigned  MaxOutstanding = 8,
  parameter type          burst_req_t    = idma_legacy_burst_scheduler_pkg::burst_req_t,
  localparam int unsigned IdxWidth       = $clog2(NumReq),
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  burst_req_t          req_i [NumReq],
  input  logic [NumReq-1:0]   req_valid_i,
`ifdef IDMA_SCHED_PRIO_EN
  input  logic [NumReq-1:0]   prio_i,
`endif
  output logic [NumReq-1:0]   req_ready_o,
  output logic [NumReq-1:0]   req_complete_o,
  output burst_req_t          burst_req_o,
  output logic                valid_o,
  input  logic                ready_i,
  input  logic                trans_complete_i,
  input  logic                backend_idle_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                idle_o,
  output logic                err_o
);

  localparam int unsigned PtrAw = $clog2(MaxOutstanding);
  localparam int unsigned PtrW  = PtrAw + 1;

  typedef enum logic {ArbFree, ArbLocked} arb_state_e;

  arb_state_e                r_arb_state;
  logic [IdxWidth-1:0]       r_lock_idx;
  logic [IdxWidth-1:0]       r_rr_ptr;
  logic [IdxWidth-1:0]       r_fifo_idx [MaxOutstanding];
  logic [MaxOutstanding-1:0] r_fifo_local;
  logic [PtrW-1:0]           r_wptr;
  logic [PtrW-1:0]           r_rptr;
  logic [CntWidth-1:0]       r_count;
  logic                      r_err;

  logic [NumReq-1:0]   w_cand;
  logic                w_hi_found, w_lo_found;
  logic [IdxWidth-1:0] w_hi_idx, w_lo_idx, w_gnt_idx, w_head_idx;
  logic                w_empty, w_full, w_gnt_act, w_gnt_zero, w_accept;
  logic                w_pop, w_err_set, w_head_local;

  // Candidates at or above the pointer win; otherwise wrap to the lowest candidate.
  always_comb begin
    w_cand = req_valid_i;
`ifdef IDMA_SCHED_PRIO_EN
    if ((req_valid_i & prio_i) != '0) w_cand = req_valid_i & prio_i;
`endif
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_cand[i] && (IdxWidth'(i) >= r_rr_ptr) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IdxWidth'(i);
      end
      if (w_cand[i] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    w_gnt_idx   = (r_arb_state == ArbLocked) ? r_lock_idx : (w_hi_found ? w_hi_idx : w_lo_idx);
    w_gnt_act   = !w_full && ((r_arb_state == ArbLocked) || w_lo_found);
    w_gnt_zero  = (req_i[w_gnt_idx].num_bytes == '0);
    valid_o     = w_gnt_act && !w_gnt_zero;
    burst_req_o = valid_o ? req_i[w_gnt_idx] : '0;
    w_accept    = w_gnt_act && (w_gnt_zero || ready_i);
    req_ready_o = '0;
    if (w_accept) req_ready_o[w_gnt_idx] = 1'b1;
  end

  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[PtrAw] != r_rptr[PtrAw]) &&
                        (r_wptr[PtrAw-1:0] == r_rptr[PtrAw-1:0]);
  assign w_head_idx   = r_fifo_idx[r_rptr[PtrAw-1:0]];
  assign w_head_local = r_fifo_local[r_rptr[PtrAw-1:0]];
  // Local heads retire on their own, so a backend pulse against one is unmatched.
  assign w_pop        = !w_empty && (w_head_local || trans_complete_i);
  assign w_err_set    = trans_complete_i && (w_empty || w_head_local);

  always_comb begin
    req_complete_o = '0;
    if (w_pop) req_complete_o[w_head_idx] = 1'b1;
  end

  assign outstanding_o = r_count;
  assign idle_o        = w_empty && backend_idle_i;
  assign err_o         = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_arb_state  <= ArbFree;
      r_lock_idx   <= '0;
      r_rr_ptr     <= '0;
      r_fifo_local <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) r_fifo_idx[i] <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fifo_idx[r_wptr[PtrAw-1:0]]   <= w_gnt_idx;
        r_fifo_local[r_wptr[PtrAw-1:0]] <= w_gnt_zero;
        r_wptr      <= r_wptr + PtrW'(1);
        r_rr_ptr    <= (w_gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : w_gnt_idx + IdxWidth'(1);
        r_arb_state <= ArbFree;
      end else if (valid_o) begin
        r_arb_state <= ArbLocked;
        r_lock_idx  <= w_gnt_idx;
      end
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      if (w_accept && !w_pop)      r_count <= r_count + CntWidth'(1);
      else if (!w_accept && w_pop) r_count <= r_count - CntWidth'(1);
      if (w_err_set) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_idma_legacy_burst_scheduler.sv
// Bench for idma_legacy_burst_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations and randomized traffic.
module tb_idma_legacy_burst_scheduler;
  localparam int NR = 4;
  localparam int MO = 8;
  localparam int CW = 4;
  typedef idma_legacy_burst_scheduler_pkg::burst_req_t breq_t;

  logic          clk = 1'b0;
  logic          rst_ni;
  breq_t         req_i [NR];
  logic [NR-1:0] req_valid_i, req_ready_o, req_complete_o;
`ifdef IDMA_SCHED_PRIO_EN
  logic [NR-1:0] prio_i;
`endif
  breq_t         burst_req_o;
  logic          valid_o, ready_i, trans_complete_i, backend_idle_i;
  logic [CW-1:0] outstanding_o;
  logic          idle_o, err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  idma_legacy_burst_scheduler #(.NumReq(NR), .MaxOutstanding(MO)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_i            (req_i),
    .req_valid_i      (req_valid_i),
`ifdef IDMA_SCHED_PRIO_EN
    .prio_i           (prio_i),
`endif
    .req_ready_o      (req_ready_o),
    .req_complete_o   (req_complete_o),
    .burst_req_o      (burst_req_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .trans_complete_i (trans_complete_i),
    .backend_idle_i   (backend_idle_i),
    .outstanding_o    (outstanding_o),
    .idle_o           (idle_o),
    .err_o            (err_o)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of issued bursts, shared rr pointer, lock holder (-1 = none).
  typedef struct {
    int idx;
    bit loc;
  } ent_t;
  ent_t          m_q[$];
  int            m_rr   = 0;
  int            m_lock = -1;
  bit            m_err  = 0;
  logic [NR-1:0] m_acc_mask = '0;

  function automatic int pick(input logic [NR-1:0] v, input logic [NR-1:0] p);
    logic [NR-1:0] m;
    m = v;
    if ((v & p) != '0) m = v & p;
    for (int k = 0; k < NR; k++)
      if (m[(m_rr + k) % NR]) return (m_rr + k) % NR;
    return -1;
  endfunction

  always @(negedge clk) begin : p_check
    int            g;
    bit            zero, acc, e_val, pop, tc_err;
    logic [NR-1:0] e_rdy, e_cmp, pv;
    breq_t         e_br;
`ifdef IDMA_SCHED_PRIO_EN
    pv = prio_i;
`else
    pv = '0;
`endif
    if (!rst_ni) begin
      m_q.delete();
      m_rr   = 0;
      m_lock = -1;
      m_err  = 0;
    end
    g = -1;
    if (m_q.size() < MO) g = (m_lock >= 0) ? m_lock : pick(req_valid_i, pv);
    zero = 0;
    e_br = '0;
    if (g >= 0) zero = (req_i[g].num_bytes == 0);
    e_val = (g >= 0) && !zero;
    if (e_val) e_br = req_i[g];
    acc   = (g >= 0) && (zero || ready_i);
    e_rdy = '0;
    if (acc) e_rdy[g] = 1'b1;
    pop    = 0;
    tc_err = 0;
    e_cmp  = '0;
    if (m_q.size() > 0 && (m_q[0].loc || trans_complete_i)) begin
      pop = 1;
      e_cmp[m_q[0].idx] = 1'b1;
    end
    if (trans_complete_i && (m_q.size() == 0 || m_q[0].loc)) tc_err = 1;

    chk("cyc_valid",       128'(valid_o),        128'(e_val));
    chk("cyc_burst",       128'(burst_req_o),    128'(e_br));
    chk("cyc_ready",       128'(req_ready_o),    128'(e_rdy));
    chk("cyc_complete",    128'(req_complete_o), 128'(e_cmp));
    chk("cyc_outstanding", 128'(outstanding_o),  128'(m_q.size()));
    chk("cyc_idle",        128'(idle_o),         128'(m_q.size() == 0 && backend_idle_i));
    chk("cyc_err",         128'(err_o),          128'(m_err));

    if (rst_ni) begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back('{idx: g, loc: zero});
        m_rr   = (g + 1) % NR;
        m_lock = -1;
      end else if (e_val) begin
        m_lock = g;
      end
      if (tc_err) m_err = 1;
      m_acc_mask = e_rdy;
    end else begin
      m_acc_mask = '0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input int nb);
    req_i[i] = '{src_addr: $urandom, dst_addr: $urandom, num_bytes: 16'(nb)};
  endtask

  task automatic drain();
    for (int c = 0; c < 64; c++) begin
      cyc();
      req_valid_i = '0;
      if (m_q.size() == 0) begin
        trans_complete_i = 1'b0;
        break;
      end
      trans_complete_i = !m_q[0].loc;
    end
    #2;
    chk("drain_empty", 128'(outstanding_o), 128'(0));
  endtask

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      cyc();
      for (int i = 0; i < NR; i++) begin
        if (m_acc_mask[i]) req_valid_i[i] = 1'b0;
        if (!req_valid_i[i] && $urandom_range(0, 99) < 45) begin
          setreq(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4096)));
          req_valid_i[i] = 1'b1;
        end
      end
      ready_i          = ($urandom_range(0, 2) != 0);
      trans_complete_i = (m_q.size() > 0) && !m_q[0].loc && ($urandom_range(0, 1) == 1);
      backend_idle_i   = ($urandom_range(0, 1) == 1);
`ifdef IDMA_SCHED_PRIO_EN
      prio_i = NR'($urandom);
`endif
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : p_drive
    logic [NR-1:0] exp4;
    breq_t         r2;
    rst_ni           = 1'b0;
    req_valid_i      = '0;
    ready_i          = 1'b0;
    trans_complete_i = 1'b0;
    backend_idle_i   = 1'b1;
`ifdef IDMA_SCHED_PRIO_EN
    prio_i = '0;
`endif
    for (int i = 0; i < NR; i++) setreq(i, 16);
    #2;
    chk("rst_outstanding", 128'(outstanding_o),  128'(0));
    chk("rst_valid",       128'(valid_o),        128'(0));
    chk("rst_ready",       128'(req_ready_o),    128'(0));
    chk("rst_complete",    128'(req_complete_o), 128'(0));
    chk("rst_err",         128'(err_o),          128'(0));
    chk("rst_idle",        128'(idle_o),         128'(1));
    backend_idle_i = 1'b0;
    #1;
    chk("rst_idle_follows", 128'(idle_o), 128'(0));
    cyc();
    cyc();
    rst_ni = 1'b1;

    // Round-robin over four busy requesters
    cyc();
    for (int i = 0; i < NR; i++) setreq(i, 64 * (i + 1));
    req_valid_i = '1;
    ready_i     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      #2;
      exp4 = 4'b0001 << (k % NR);
      chk("t1_grant", 128'(req_ready_o), 128'(exp4));
    end
    cyc();
    req_valid_i = '0;
    ready_i     = 1'b0;
    #2;
    chk("t1_outstanding", 128'(outstanding_o), 128'(5));
    drain();

    // Grant lock while the backend stalls
    cyc();
    setreq(2, 200);
    setreq(0, 100);
    r2          = req_i[2];
    req_valid_i = 4'b0100;
    ready_i     = 1'b0;
    #2;
    chk("t2_valid", 128'(valid_o), 128'(1));
    chk("t2_hold0", 128'(burst_req_o), 128'(r2));
    cyc();
    req_valid_i = 4'b0101;
    #2;
    chk("t2_hold1", 128'(burst_req_o), 128'(r2));
    cyc();
    #2;
    chk("t2_hold2", 128'(burst_req_o), 128'(r2));
    cyc();
    ready_i = 1'b1;
    #2;
    chk("t2_accept2", 128'(req_ready_o), 128'(4'b0100));
    cyc();
    req_valid_i = 4'b0001;
    #2;
    chk("t2_then0", 128'(req_ready_o), 128'(4'b0001));
    drain();

    // In-order completion routing
    cyc();
    setreq(1, 300);
    setreq(3, 400);
    req_valid_i = 4'b1010;
    ready_i     = 1'b1;
    #2;
    chk("t3_grant_a", 128'(req_ready_o), 128'(4'b0010));
    cyc();
    #2;
    chk("t3_grant_b", 128'(req_ready_o), 128'(4'b1000));
    cyc();
    #2;
    chk("t3_grant_c", 128'(req_ready_o), 128'(4'b0010));
    cyc();
    req_valid_i      = '0;
    ready_i          = 1'b0;
    trans_complete_i = 1'b1;
    #2;
    chk("t3_cmp_a", 128'(req_complete_o), 128'(4'b0010));
    cyc();
    #2;
    chk("t3_cmp_b", 128'(req_complete_o), 128'(4'b1000));
    cyc();
    #2;
    chk("t3_cmp_c", 128'(req_complete_o), 128'(4'b0010));
    cyc();
    trans_complete_i = 1'b0;
    backend_idle_i   = 1'b1;
    #2;
    chk("t3_outstanding", 128'(outstanding_o), 128'(0));
    chk("t3_idle",        128'(idle_o),        128'(1));

    // Zero-length burst waits behind an earlier backend burst
    cyc();
    setreq(0, 32);
    req_valid_i = 4'b0001;
    ready_i     = 1'b1;
    #2;
    chk("t4_acc_burst", 128'(req_ready_o), 128'(4'b0001));
    cyc();
    setreq(0, 0);
    ready_i = 1'b0;
    #2;
    chk("t4_zero_ready",   128'(req_ready_o), 128'(4'b0001));
    chk("t4_zero_novalid", 128'(valid_o),     128'(0));
    cyc();
    req_valid_i = '0;
    #2;
    chk("t4_wait_a", 128'(req_complete_o), 128'(0));
    cyc();
    #2;
    chk("t4_wait_b", 128'(req_complete_o), 128'(0));
    cyc();
    trans_complete_i = 1'b1;
    #2;
    chk("t4_cmp_backend", 128'(req_complete_o), 128'(4'b0001));
    cyc();
    trans_complete_i = 1'b0;
    #2;
    chk("t4_cmp_local", 128'(req_complete_o), 128'(4'b0001));
    cyc();
    #2;
    chk("t4_done", 128'(outstanding_o), 128'(0));

    // Full tracking FIFO blocks grants until a slot frees
    cyc();
    for (int i = 0; i < NR; i++) setreq(i, 128);
    req_valid_i = '1;
    ready_i     = 1'b1;
    repeat (7) cyc();
    cyc();
    trans_complete_i = 1'b1;
    #2;
    chk("t5_full_ready", 128'(req_ready_o),    128'(0));
    chk("t5_full_valid", 128'(valid_o),        128'(0));
    chk("t5_full_count", 128'(outstanding_o),  128'(8));
    chk("t5_full_cmp",   128'(req_complete_o), 128'(4'b0010));
    cyc();
    trans_complete_i = 1'b0;
    #2;
    chk("t5_resume", 128'(req_ready_o), 128'(4'b0010));
    drain();

    // Unmatched completion
    cyc();
    trans_complete_i = 1'b1;
    #2;
    chk("t6_no_cmp",  128'(req_complete_o), 128'(0));
    chk("t6_err_pre", 128'(err_o),          128'(0));
    cyc();
    trans_complete_i = 1'b0;
    #2;
    chk("t6_err", 128'(err_o), 128'(1));
    cyc();
    #2;
    chk("t6_err_sticky", 128'(err_o), 128'(1));

`ifdef IDMA_SCHED_PRIO_EN
    cyc();
    for (int i = 0; i < NR; i++) setreq(i, 512);
    req_valid_i = '1;
    prio_i      = 4'b0100;
    ready_i     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      #2;
      chk("tp_prio", 128'(req_ready_o), 128'(4'b0100));
    end
    prio_i = '0;
    drain();
`endif

    rand_cycles(1500);

    // Asynchronous reset in the middle of traffic
    cyc();
    req_valid_i      = '0;
    trans_complete_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_count", 128'(outstanding_o), 128'(0));
    chk("async_rst_err",   128'(err_o),         128'(0));
    chk("async_rst_valid", 128'(valid_o),       128'(0));
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();
    trans_complete_i = 1'b1;
    #2;
    chk("post_rst_cmp", 128'(req_complete_o), 128'(0));
    cyc();
    trans_complete_i = 1'b0;
    #2;
    chk("post_rst_err", 128'(err_o), 128'(1));

    rand_cycles(1500);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
